twiddle_gen: RTL and testbench

//  Parametrised twiddle-factor generator for the radix-2 DIT FFT/IFFT datapath. Successor to the fixed

---
 rtl/twiddle_gen.sv | 243 ++++++++++++++++++++++++
 tb/tb_twiddle_gen.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/twiddle_gen.sv
// twiddle_gen: parametrised twiddle-factor generator for the radix-2 DIT FFT/IFFT datapath.
//
// Holds a quarter-wave cosine table (NFFT/4+1 words, Q[m] = round(2^NBF_W*cos(2*pi*m/NFFT)))
// and unfolds it to the full circle by quadrant symmetry. Requests come either directly
// (i_valid/i_k) or from a per-stage sequencer (i_start/i_stage) that streams the NFFT/2
// twiddles of one butterfly stage. Results appear two enabled cycles after issue.
//
// Ports
//   i_clk     clock, rising edge
//   i_rst_n   asynchronous active-low reset
//   i_en      global clock enable, 0 freezes every register
//   i_inv     0: FFT (o_im = -sin), 1: IFFT (o_im = +sin), sampled with each request
//   i_valid   direct lookup request (single cycle, ignored while sequencing or starting)
//   i_k       direct index 0..NFFT-1
//   i_start   start the sequencer for stage i_stage (ignored if i_stage > LOG2N-1)
//   i_stage   DIT stage 0..LOG2N-1
//   o_busy    sequencer running
//   o_valid   o_re/o_im/o_k valid this cycle
//   o_last    final twiddle of a sequenced stage (qualified by o_valid)
//   o_k       index of the twiddle presented
//   o_re      cos(2*pi*k/NFFT), signed Q(NB_W,NBF_W)
//   o_im      -sin (FFT) or +sin (IFFT), same format

module twiddle_gen #(
  parameter int NFFT  = 32,
  parameter int NB_W  = 17,
  parameter int NBF_W = 10,
  localparam int LOG2N = $clog2(NFFT),
  localparam int SW    = $clog2(LOG2N)
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_en,
  input  logic                   i_inv,
  input  logic                   i_valid,
  input  logic [LOG2N-1:0]       i_k,
  input  logic                   i_start,
  input  logic [SW-1:0]          i_stage,
  output logic                   o_busy,
  output logic                   o_valid,
  output logic                   o_last,
  output logic [LOG2N-1:0]       o_k,
  output logic signed [NB_W-1:0] o_re,
  output logic signed [NB_W-1:0] o_im
);

  // Table address width: NFFT/4+1 entries always need exactly LOG2N-1 bits.
  localparam int AW = LOG2N - 1;

  localparam logic [SW-1:0]    MAX_STAGE = SW'(LOG2N - 1);
  localparam logic [LOG2N-2:0] J_ONES    = '1;
  localparam logic [LOG2N-2:0] J_ONE     = (LOG2N-1)'(1'b1);
  localparam logic [AW-1:0]    QN        = AW'(NFFT / 4);

  // Fixed-point constants for the elaboration-time cosine evaluation (scale 2^30).
  localparam int     QS      = 32'sd30;
  localparam longint PI_Q30  = 64'sd3373259426;
  localparam longint ONE_Q30 = 64'sd1073741824;

  // round(2^NBF_W * cos(2*pi*m/NFFT)) for 0 <= m <= NFFT/4, via a Taylor series in
  // 64-bit fixed point. The table is built at elaboration from the same rounding rule
  // as the reference hex image, so no image file has to ship with the block.
  function automatic longint q_val(input int m);
    longint x, x2, term, acc, den;
    x    = (PI_Q30 * 64'sd2 * longint'(m)) / longint'(NFFT);
    x2   = (x * x) >>> QS;
    term = ONE_Q30;
    acc  = ONE_Q30;
    for (int n = 1; n <= 32'sd12; n++) begin
      den  = (64'sd2 * n - 64'sd1) * (64'sd2 * n);
      term = -((term * x2) >>> QS) / den;
      acc  = acc + term;
    end
    return ((acc <<< NBF_W) + (ONE_Q30 >>> 1)) >>> QS;
  endfunction

  logic signed [NB_W-1:0] rom_s [0:NFFT/4];

  for (genvar m = 0; m <= NFFT / 4; m++) begin : g_rom
    localparam logic signed [NB_W-1:0] QV = NB_W'(q_val(m));
    assign rom_s[m] = QV;
  end

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_r, state_n_s;
  logic [SW-1:0]    s_r, s_n_s;
  logic             inv_r, inv_n_s;
  logic [LOG2N-2:0] j_r, j_n_s;

  logic [LOG2N-2:0] mask_s;
  logic [SW-1:0]    shamt_s;
  logic [LOG2N-1:0] kseq_s;

  logic             iss_v_s, iss_inv_s, iss_last_s;
  logic [LOG2N-1:0] iss_k_s;
  logic [AW-1:0]    a_s, b_s;

  logic             v1_r, inv1_r, last1_r;
  logic [AW-1:0]    a1_r, b1_r;
  logic [1:0]       q1_r;
  logic [LOG2N-1:0] k1_r;

  logic signed [NB_W-1:0] c_s, sn_s, cos_s, sin_s, im_s;

  // Sequencer index: k = (j mod 2^s) << (LOG2N-1-s).
  always_comb begin
    mask_s  = ~(J_ONES << s_r);
    shamt_s = MAX_STAGE - s_r;
    kseq_s  = {1'b0, j_r & mask_s} << shamt_s;
  end

  // Sequencer next state and selection of the index issued into the pipeline.
  always_comb begin
    state_n_s  = state_r;
    s_n_s      = s_r;
    inv_n_s    = inv_r;
    j_n_s      = j_r;
    iss_v_s    = 1'b0;
    iss_k_s    = i_k;
    iss_inv_s  = i_inv;
    iss_last_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (i_start) begin
          // A start for a non-existent stage is dropped together with any direct request.
          if (i_stage <= MAX_STAGE) begin
            state_n_s = RUN;
            s_n_s     = i_stage;
            inv_n_s   = i_inv;
            j_n_s     = '0;
          end else begin
            state_n_s = IDLE;
          end
        end else if (i_valid) begin
          iss_v_s = 1'b1;
        end else begin
          iss_v_s = 1'b0;
        end
      end
      RUN: begin
        iss_v_s   = 1'b1;
        iss_k_s   = kseq_s;
        iss_inv_s = inv_r;
        if (j_r == J_ONES) begin
          iss_last_s = 1'b1;
          state_n_s  = IDLE;
          j_n_s      = '0;
        end else begin
          j_n_s = j_r + J_ONE;
        end
      end
      default: begin
        state_n_s = IDLE;
      end
    endcase
  end

  // Sequencer state, latched stage/direction, step counter and busy flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= IDLE;
      s_r     <= '0;
      inv_r   <= 1'b0;
      j_r     <= '0;
      o_busy  <= 1'b0;
    end else if (i_en) begin
      state_r <= state_n_s;
      s_r     <= s_n_s;
      inv_r   <= inv_n_s;
      j_r     <= j_n_s;
      o_busy  <= (state_n_s == RUN);
    end
  end

  // Quadrant fold: a addresses cos of the residual angle, b its complement (the sine).
  always_comb begin
    a_s = {1'b0, iss_k_s[LOG2N-3:0]};
    b_s = QN - a_s;
  end

  // Stage 1: registered table addresses and request attributes.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      v1_r    <= 1'b0;
      a1_r    <= '0;
      b1_r    <= '0;
      q1_r    <= 2'b00;
      inv1_r  <= 1'b0;
      k1_r    <= '0;
      last1_r <= 1'b0;
    end else if (i_en) begin
      v1_r    <= iss_v_s;
      a1_r    <= a_s;
      b1_r    <= b_s;
      q1_r    <= iss_k_s[LOG2N-1:LOG2N-2];
      inv1_r  <= iss_inv_s;
      k1_r    <= iss_k_s;
      last1_r <= iss_last_s;
    end
  end

  // Stage 2 datapath: table read, quadrant unfolding and direction-dependent sine sign.
  always_comb begin
    c_s  = rom_s[a1_r];
    sn_s = rom_s[b1_r];
    case (q1_r)
      2'd0: begin cos_s = c_s;   sin_s = sn_s;  end
      2'd1: begin cos_s = -sn_s; sin_s = c_s;   end
      2'd2: begin cos_s = -c_s;  sin_s = -sn_s; end
      2'd3: begin cos_s = sn_s;  sin_s = -c_s;  end
      default: begin cos_s = c_s; sin_s = sn_s; end
    endcase
    if (inv1_r) begin
      im_s = sin_s;
    end else begin
      im_s = -sin_s;
    end
  end

  // Stage 2: output registers; data only reloads when a twiddle is presented.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid <= 1'b0;
      o_last  <= 1'b0;
      o_k     <= '0;
      o_re    <= '0;
      o_im    <= '0;
    end else if (i_en) begin
      o_valid <= v1_r;
      o_last  <= v1_r & last1_r;
      if (v1_r) begin
        o_k  <= k1_r;
        o_re <= cos_s;
        o_im <= im_s;
      end
    end
  end

endmodule

// File: tb/tb_twiddle_gen.sv
// tb_twiddle_gen: self-checking bench for twiddle_gen (NFFT=32, NB_W=17, NBF_W=10).
// Expected twiddles come from real-valued cos/sin with round-half-away rounding; the
// expected order and timing of outputs follow the request/stage rules, tracked by
// counting enabled clock edges.

module tb_twiddle_gen;

  localparam real PI = 3.14159265358979323846;

  logic               i_clk, i_rst_n, i_en, i_inv, i_valid, i_start;
  logic [4:0]         i_k;
  logic [2:0]         i_stage;
  logic               o_busy, o_valid, o_last;
  logic [4:0]         o_k;
  logic signed [16:0] o_re, o_im;

  twiddle_gen #(.NFFT(32), .NB_W(17), .NBF_W(10)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (i_en),
    .i_inv   (i_inv),
    .i_valid (i_valid),
    .i_k     (i_k),
    .i_start (i_start),
    .i_stage (i_stage),
    .o_busy  (o_busy),
    .o_valid (o_valid),
    .o_last  (o_last),
    .o_k     (o_k),
    .o_re    (o_re),
    .o_im    (o_im)
  );

  typedef struct {
    logic [63:0] val;
    int          tag;
  } exp_t;

  exp_t expq[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cnt     = 0;      // enabled clock edges seen so far
  int   seq_t0  = -1000;  // cnt value of the interval in which the last start was accepted

  // Clock generation.
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // Count enabled edges; this is the time base for latency and busy expectations.
  always @(posedge i_clk) begin
    if (i_en) cnt <= cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int rnd(input real x);
    if (x >= 0.0) return $rtoi($floor(x + 0.5));
    else return -$rtoi($floor(-x + 0.5));
  endfunction

  function automatic logic [63:0] pack(input bit last, input int k, input int re, input int im);
    logic [4:0]  kk;
    logic [16:0] r17, i17;
    kk  = 5'(k);
    r17 = 17'(re);
    i17 = 17'(im);
    return {24'd0, last, kk, r17, i17};
  endfunction

  function automatic bit seq_running();
    return (cnt >= seq_t0 + 1) && (cnt <= seq_t0 + 16);
  endfunction

  task automatic push_exp(input logic [63:0] v, input int tag);
    exp_t e;
    e.val = v;
    e.tag = tag;
    expq.push_back(e);
  endtask

  task automatic push_model(input int k, input bit inv, input bit last, input int tag);
    real ang;
    int  re, sn, im;
    ang = 2.0 * PI * real'(k) / 32.0;
    re  = rnd(1024.0 * $cos(ang));
    sn  = rnd(1024.0 * $sin(ang));
    im  = inv ? sn : -sn;
    push_exp(pack(last, k, re, im), tag);
  endtask

  // One clock interval of stimulus; the model records what the interval should produce.
  task automatic cyc(input bit en, input bit start, input int stage, input bit valid,
                     input int k, input bit inv);
    i_en    = en;
    i_start = start;
    i_stage = 3'(stage);
    i_valid = valid;
    i_k     = 5'(k);
    i_inv   = inv;
    if (en && !seq_running()) begin
      if (start) begin
        if (stage <= 4) begin
          seq_t0 = cnt;
          for (int j = 0; j < 16; j++)
            push_model((j % (1 << stage)) * (1 << (4 - stage)), inv, j == 15, cnt + 1 + j);
        end
      end else if (valid) begin
        push_model(k, inv, 1'b0, cnt);
      end
    end
    @(posedge i_clk);
    #1;
  endtask

  // Direct request with a hand-computed expected twiddle.
  task automatic cyc_const(input int k, input bit inv, input int re, input int im);
    i_en    = 1'b1;
    i_start = 1'b0;
    i_valid = 1'b1;
    i_k     = 5'(k);
    i_inv   = inv;
    push_exp(pack(1'b0, k, re, im), cnt);
    @(posedge i_clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && (expq.size() > 0 || seq_running()); i++)
      cyc(1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
    cyc(1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
    check("drain_empty", 64'(expq.size()), 64'd0);
  endtask

  task automatic check_reset_outputs();
    check("rst_valid", {63'd0, o_valid}, 64'd0);
    check("rst_last",  {63'd0, o_last},  64'd0);
    check("rst_busy",  {63'd0, o_busy},  64'd0);
    check("rst_re",    64'(o_re),        64'd0);
    check("rst_im",    64'(o_im),        64'd0);
  endtask

  // Output monitor: an output is consumed at the next edge only if that edge is enabled.
  always @(negedge i_clk) begin
    exp_t e;
    if (i_rst_n) begin
      check("busy", {63'd0, o_busy}, {63'd0, seq_running()});
      if (o_valid && i_en) begin
        if (expq.size() == 0) begin
          check("spurious_valid", {63'd0, o_valid}, 64'd0);
        end else begin
          e = expq.pop_front();
          check("out", {24'd0, o_last, o_k, o_re, o_im}, e.val);
          check("latency", 64'(cnt), 64'(e.tag + 2));
        end
      end else if (!o_valid) begin
        check("last_wo_valid", {63'd0, o_last}, 64'd0);
      end
    end
  end

  initial begin
    i_rst_n = 1'b0;
    i_en    = 1'b0;
    i_inv   = 1'b0;
    i_valid = 1'b0;
    i_start = 1'b0;
    i_k     = 5'd0;
    i_stage = 3'd0;
    repeat (3) @(posedge i_clk);
    #1;
    check_reset_outputs();
    i_rst_n = 1'b1;
    cyc(1'b1, 1'b0, 0, 1'b0, 0, 1'b0);

    // Direct FFT lookups, back to back.
    cyc_const(0, 1'b0, 1024, 0);
    cyc_const(1, 1'b0, 1004, -200);
    cyc_const(4, 1'b0, 724, -724);
    cyc_const(8, 1'b0, 0, -1024);
    cyc_const(15, 1'b0, -1004, -200);
    // Direct IFFT lookups and a third-quadrant-boundary FFT lookup.
    cyc_const(1, 1'b1, 1004, 200);
    cyc_const(10, 1'b1, -392, 946);
    cyc_const(20, 1'b1, -724, -724);
    cyc_const(31, 1'b1, 1004, -200);
    cyc_const(24, 1'b0, 0, 1024);
    drain();

    // Stage sequences.
    cyc(1'b1, 1'b1, 4, 1'b0, 0, 1'b0);
    drain();
    cyc(1'b1, 1'b1, 2, 1'b0, 0, 1'b1);
    drain();
    cyc(1'b1, 1'b1, 0, 1'b0, 0, 1'b0);
    drain();

    // Stall for three cycles in the middle of a run.
    cyc(1'b1, 1'b1, 4, 1'b0, 0, 1'b0);
    repeat (5) cyc(1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
    repeat (3) cyc(1'b0, 1'b0, 0, 1'b1, $urandom_range(0, 31), 1'b1);
    drain();

    // Requests during RUN and starts for invalid stages are ignored.
    cyc(1'b1, 1'b1, 3, 1'b0, 0, 1'b1);
    for (int i = 0; i < 10; i++)
      cyc(1'b1, i[0], 2, 1'b1, $urandom_range(0, 31), 1'b0);
    drain();
    for (int s = 5; s < 8; s++)
      cyc(1'b1, 1'b1, s, 1'b1, 7, 1'b0);
    drain();

    // Full sweep of all indices in both directions.
    for (int inv = 0; inv < 2; inv++)
      for (int k = 0; k < 32; k++)
        cyc(1'b1, 1'b0, 0, 1'b1, k, inv[0]);
    drain();

    // Randomized mix of direct requests, starts, stalls and stage numbers.
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 9) != 0, $urandom_range(0, 15) == 0, $urandom_range(0, 7),
          $urandom_range(0, 1) == 1, $urandom_range(0, 31), $urandom_range(0, 1) == 1);
    drain();

    // Reset in the middle of a run aborts it; nothing resumes without a new start.
    cyc(1'b1, 1'b1, 4, 1'b0, 0, 1'b0);
    repeat (6) cyc(1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
    #2;
    i_rst_n = 1'b0;
    #1;
    check_reset_outputs();
    expq.delete();
    seq_t0 = -1000;
    @(posedge i_clk);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    repeat (20) cyc(1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
    cyc(1'b1, 1'b1, 1, 1'b0, 0, 1'b1);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
